perip_timecmp: RTL
==================

PERIP_TIMECMP -- requirements
Module: perip_timecmp

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50, meaning clk cycles per 1 us tick (legal range >= 2).
REQ-002 SHALL provide port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port ena, input, 1, bus access strobe, one access per cycle it is high.
REQ-005 SHALL provide port rw, input, 1, access direction: 1 = write, 0 = read.
REQ-006 SHALL provide port addr, input, 32, byte address; decoded as 0x0 MTIME_LO, 0x4 MTIME_HI, 0x8 CMP_LO, 0xC CMP_HI.
REQ-007 SHALL provide port wdata, input, 32, write data.
REQ-008 SHALL provide port rdata, output, 32, registered read data.
REQ-009 SHALL provide port irq, output, 1, registered timer interrupt, level-sensitive.

Function
REQ-010 SHALL hold a prescaler counting 0..CLK_DIV-1; a tick SHALL occur in the cycle the prescaler equals CLK_DIV-1, and the prescaler then returns to 0.
REQ-011 SHALL hold a 64-bit mtime incremented by 1 on each tick, wrapping from 0xFFFFFFFF_FFFFFFFF to 0.
REQ-012 SHALL, on a write to MTIME_LO or MTIME_HI, load that 32-bit half from wdata, keep the other half, clear the prescaler, and suppress any tick in that cycle.
REQ-013 SHALL hold a 64-bit committed mtimecmp and a 32-bit cmp_stage register.
REQ-014 SHALL, on a write to CMP_LO, load cmp_stage only; committed mtimecmp SHALL be unchanged.
REQ-015 SHALL, on a write to CMP_HI, commit mtimecmp = {wdata, cmp_stage} atomically in one cycle.
REQ-016 SHALL, on a read of MTIME_LO, return mtime[31:0] and capture mtime[63:32] into a 32-bit snapshot in the same cycle.
REQ-017 SHALL, on a read of MTIME_HI, return the snapshot, not live mtime[63:32].
REQ-018 SHALL return committed mtimecmp[31:0] for a CMP_LO read and mtimecmp[63:32] for a CMP_HI read; cmp_stage SHALL NOT be readable.
REQ-019 SHALL update rdata exactly one cycle after a read access (ena=1, rw=0), and SHALL hold rdata unchanged in all other cycles, including writes.
REQ-020 SHALL, for any addr with addr[31:4] != 0 or addr[1:0] != 0, return rdata = 0 on read and ignore the write.
REQ-021 SHALL compute irq each cycle as registered (mtime >= mtimecmp), unsigned 64-bit, one cycle after the values that produce it.
REQ-022 SHALL, when a tick and a CMP_HI commit occur in the same cycle, compare the post-increment mtime with the newly committed mtimecmp, visible on irq in the next cycle.
REQ-023 SHALL treat mtime wrap-around as a plain unsigned value: irq deasserts after wrap if mtimecmp > 0.
REQ-024 SHALL sample mtime for reads before the same-cycle increment; a read and tick in one cycle returns the pre-tick value.

Reset
REQ-025 SHALL, on rst low, asynchronously set prescaler=0, mtime=0, snapshot=0, cmp_stage=0, mtimecmp=0xFFFFFFFF_FFFFFFFF, rdata=0, irq=0.
REQ-026 SHALL resume counting from prescaler=0 on the first rising clk edge after rst is released; reset asserted mid-operation SHALL discard any staged CMP_LO write.

Verification
REQ-027 SHALL cover reset values and ticking: release rst, run 150 cycles at CLK_DIV=50 -> mtime = 3, irq = 0, CMP_HI read returns 0xFFFFFFFF.
REQ-028 SHALL cover the atomic compare update: write CMP_LO=0x10, wait 2000 cycles -> irq stays 0; write CMP_HI=0 -> irq=1 on the second edge after the write (mtime >= 0x10).
REQ-029 SHALL cover the snapshot read: write MTIME_HI=0, write MTIME_LO=0xFFFFFFFF, read MTIME_LO at prescaler CLK_DIV-1, then read MTIME_HI after the carry -> returns 0xFFFFFFFF then 0x00000000.
REQ-030 SHALL cover wrap-around: load mtime=0xFFFFFFFF_FFFFFFFF, mtimecmp=0xFFFFFFFF_FFFFFFFF -> irq=1; after the next tick mtime=0 and irq=0.
REQ-031 SHALL cover asynchronous reset: drive rst low mid-tick with staged CMP_LO=0x5 -> all outputs 0 immediately without a clk edge; a subsequent CMP_HI=0 write commits mtimecmp = 0x00000000_00000000.
REQ-032 SHALL cover the unmapped address: read addr 0x10 -> rdata=0; write addr 0x14 -> no register changes.

Source files
------------

// File: rtl/perip_timecmp.sv
// Machine timer peripheral: 1 us mtime counter, atomically committed 64-bit compare,
// torn-read-safe mtime snapshot and a level-sensitive registered interrupt.
module perip_timecmp #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 64;
  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    SEL_MTIME_LO = 2'd0,
    SEL_MTIME_HI = 2'd1,
    SEL_CMP_LO   = 2'd2,
    SEL_CMP_HI   = 2'd3
  } reg_sel_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] mtime_q, mtime_d;
  logic [TW-1:0] cmp_q, cmp_d;
  logic [DW-1:0] stage_q, stage_d;
  logic [DW-1:0] snap_q, snap_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic     addr_ok;
  reg_sel_e sel;
  logic     wr_en;
  logic     rd_en;
  logic     mtime_wr;
  logic     tick;

  // Only word-aligned offsets inside the 16-byte window are decoded.
  assign addr_ok  = (addr[31:4] == 28'd0) && (addr[1:0] == 2'd0);
  assign sel      = reg_sel_e'(addr[3:2]);
  assign wr_en    = ena && rw && addr_ok;
  assign rd_en    = ena && !rw;
  assign mtime_wr = wr_en && ((sel == SEL_MTIME_LO) || (sel == SEL_MTIME_HI));
  assign tick     = (presc_q == PRESC_MAX) && !mtime_wr;

  // Next-state logic for timebase, compare, snapshot and read port.
  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    stage_d = stage_q;
    snap_d  = snap_q;
    rdata_d = rdata_q;
    irq_d   = (mtime_q >= cmp_q);

    // Software writes to mtime restart the microsecond phase.
    if (mtime_wr) begin
      presc_d = '0;
      if (sel == SEL_MTIME_LO) begin
        mtime_d[31:0] = wdata;
      end else begin
        mtime_d[63:32] = wdata;
      end
    end else if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (wr_en && (sel == SEL_CMP_LO)) begin
      stage_d = wdata;
    end
    if (wr_en && (sel == SEL_CMP_HI)) begin
      cmp_d = {wdata, stage_q};
    end

    // Reads see pre-tick register values; MTIME_LO latches the upper half.
    if (rd_en) begin
      if (!addr_ok) begin
        rdata_d = '0;
      end else begin
        case (sel)
          SEL_MTIME_LO: begin
            rdata_d = mtime_q[31:0];
            snap_d  = mtime_q[63:32];
          end
          SEL_MTIME_HI: rdata_d = snap_q;
          SEL_CMP_LO:   rdata_d = cmp_q[31:0];
          SEL_CMP_HI:   rdata_d = cmp_q[63:32];
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
      stage_q <= '0;
      snap_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      stage_q <= stage_d;
      snap_q  <= snap_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
